// File: rtl/mmio_controller.sv
// mmio_controller: decodes the data-memory port into RAM accesses and a small
// peripheral bank (debounced button with press latch/counter, cycle timer,
// timer compare). MMIO loads are registered so they line up with the RAM's
// one-cycle read latency.
module mmio_controller #(
    parameter int unsigned RAM_AW          = 12,
    parameter logic [31:0] STATUS_ADDR     = 32'd1000,
    parameter logic [31:0] TIMER_ADDR      = 32'd1001,
    parameter logic [31:0] CMP_ADDR        = 32'd1002,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    input  logic              rden,
    output logic [31:0]       q_dmem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wEn,
    output logic [31:0]       ram_dataIn,
    input  logic [31:0]       ram_dataOut,
    input  logic              button_in
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } db_state_t;

    // Address decode and access qualification
    logic hit_status, hit_timer, hit_cmp, mmio_hit;
    logic wr_status, wr_timer, wr_cmp, rd_status;

    // Read-return pipeline
    logic        sel_mmio;
    logic [31:0] mmio_q;
    logic [31:0] mmio_rdata;

    // Button path
    logic            sync1, btn_sync;
    db_state_t       state, state_nxt;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;
    logic            btn_level, btn_level_nxt;
    logic            press_evt;

    // Peripheral registers
    logic        press_pending;
    logic [7:0]  press_count;
    logic [31:0] timer;
    logic [31:0] cmp;
    logic        timer_flag;
    logic [31:0] status_val;

    assign hit_status = (address_dmem == STATUS_ADDR);
    assign hit_timer  = (address_dmem == TIMER_ADDR);
    assign hit_cmp    = (address_dmem == CMP_ADDR);
    assign mmio_hit   = hit_status | hit_timer | hit_cmp;

    assign wr_status  = wren & hit_status;
    assign wr_timer   = wren & hit_timer;
    assign wr_cmp     = wren & hit_cmp;
    // A simultaneous store suppresses the clear-on-read side-effect.
    assign rd_status  = rden & ~wren & hit_status;

    assign ram_addr   = address_dmem[RAM_AW-1:0];
    assign ram_wEn    = wren & ~mmio_hit;
    assign ram_dataIn = data;

    assign status_val = {16'h0000, press_count, 5'b00000, timer_flag, press_pending, btn_level};
    assign q_dmem     = sel_mmio ? mmio_q : ram_dataOut;

    // Select the peripheral register addressed this cycle
    always_comb begin
        mmio_rdata = '0;
        if (hit_status)     mmio_rdata = status_val;
        else if (hit_timer) mmio_rdata = timer;
        else if (hit_cmp)   mmio_rdata = cmp;
    end

    // Two-flop synchronizer for the asynchronous button level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= button_in;
            btn_sync <= sync1;
        end
    end

    // Debounce FSM state, counter and debounced level registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= STABLE_LO;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            btn_level <= btn_level_nxt;
        end
    end

    // Debounce next-state: a level change needs DEBOUNCE_CYCLES identical samples
    always_comb begin
        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        btn_level_nxt = btn_level;
        press_evt     = 1'b0;
        case (state)
            STABLE_LO: begin
                if (btn_sync) begin
                    state_nxt  = CHK_HI;
                    db_cnt_nxt = DB_W'(1);
                end
            end
            CHK_HI: begin
                if (!btn_sync) begin
                    state_nxt  = STABLE_LO;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt     = STABLE_HI;
                    db_cnt_nxt    = '0;
                    btn_level_nxt = 1'b1;
                    press_evt     = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            STABLE_HI: begin
                if (!btn_sync) begin
                    state_nxt  = CHK_LO;
                    db_cnt_nxt = DB_W'(1);
                end
            end
            CHK_LO: begin
                if (btn_sync) begin
                    state_nxt  = STABLE_HI;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt     = STABLE_LO;
                    db_cnt_nxt    = '0;
                    btn_level_nxt = 1'b0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt  = STABLE_LO;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // Peripheral registers and read-return pipeline; set events beat clears
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_mmio      <= 1'b0;
            mmio_q        <= '0;
            press_pending <= 1'b0;
            press_count   <= '0;
            timer         <= '0;
            cmp           <= '1;
            timer_flag    <= 1'b0;
        end else begin
            sel_mmio <= mmio_hit;
            mmio_q   <= mmio_rdata;

            press_pending <= press_evt | (press_pending & ~rd_status);

            if (wr_status && data[31])
                press_count <= press_evt ? 8'd1 : 8'd0;
            else if (press_evt && (press_count != 8'hFF))
                press_count <= press_count + 8'd1;

            if (wr_timer) timer <= data;
            else          timer <= timer + 32'd1;

            if (wr_cmp) cmp <= data;

            timer_flag <= (timer == cmp) |
                          (timer_flag & ~(rd_status | (wr_status & data[2])));
        end
    end

endmodule

// File: tb/tb_mmio_controller.sv
// Directed self-checking bench for mmio_controller with a one-cycle-latency
// RAM model attached to the RAM-side ports.
module tb_mmio_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic        rden;
    logic [31:0] q_dmem;
    logic [11:0] ram_addr;
    logic        ram_wEn;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut = '0;
    logic        button_in;

    logic [31:0] mem [0:4095] = '{default: '0};

    int checks = 0;
    int errors = 0;

    mmio_controller #(
        .RAM_AW          (12),
        .STATUS_ADDR     (32'd1000),
        .TIMER_ADDR      (32'd1001),
        .CMP_ADDR        (32'd1002),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .rden         (rden),
        .q_dmem       (q_dmem),
        .ram_addr     (ram_addr),
        .ram_wEn      (ram_wEn),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut),
        .button_in    (button_in)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        rden         = 1'b0;
        button_in    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
        address_dmem = '0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] q);
        address_dmem = a;
        rden         = 1'b1;
        tick();
        rden         = 1'b0;
        q            = q_dmem;
        address_dmem = '0;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        apply_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++; $display("FAIL reset_q: got %h expected %h", q_dmem, 32'h0);
        end
        address_dmem = 32'd1001;
        rden = 1'b1;
        #3;
        reset = 1'b0;
        tick();
        rden = 1'b0;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++; $display("FAIL reset_timer_first_read: got %h expected %h", q_dmem, 32'h0);
        end
        do_load(32'd1002, q);
        checks++;
        if (q !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL reset_cmp: got %h expected %h", q, 32'hFFFFFFFF);
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", q, 32'h0);
        end
    endtask

    task automatic test_ram();
        logic [31:0] q;
        apply_reset();
        address_dmem = 32'd5;
        data = 32'h1234;
        wren = 1'b1;
        #1;
        checks++;
        if (ram_wEn !== 1'b1) begin
            errors++; $display("FAIL ram_wen_ram_store: got %b expected %b", ram_wEn, 1'b1);
        end
        tick();
        wren = 1'b0;
        do_load(32'd5, q);
        checks++;
        if (q !== 32'h1234) begin
            errors++; $display("FAIL ram_readback: got %h expected %h", q, 32'h1234);
        end
        // address 5096 aliases RAM word 1000 without hitting the MMIO decode
        do_store(32'd5096, 32'hCAFE0000);
        address_dmem = 32'd1000;
        data = 32'h0000_0055;
        wren = 1'b1;
        #1;
        checks++;
        if (ram_wEn !== 1'b0) begin
            errors++; $display("FAIL ram_wen_mmio_store: got %b expected %b", ram_wEn, 1'b0);
        end
        checks++;
        if (ram_addr !== 12'd1000) begin
            errors++; $display("FAIL ram_addr: got %0d expected %0d", ram_addr, 1000);
        end
        tick();
        wren = 1'b0;
        do_load(32'd5096, q);
        checks++;
        if (q !== 32'hCAFE0000) begin
            errors++; $display("FAIL ram_untouched_by_mmio: got %h expected %h", q, 32'hCAFE0000);
        end
    endtask

    task automatic test_button_press();
        logic [31:0] q;
        logic        exp;
        int          bad;
        apply_reset();
        button_in = 1'b1;
        bad = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = (k >= 18);
            checks++;
            if (dut.btn_level !== exp || dut.press_pending !== exp) begin
                errors++;
                $display("FAIL press_latency edge %0d: level %b pending %b expected %b",
                         k, dut.btn_level, dut.press_pending, exp);
            end
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h00000103) begin
            errors++; $display("FAIL status_after_press: got %h expected %h", q, 32'h00000103);
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h00000101) begin
            errors++; $display("FAIL status_reread: got %h expected %h", q, 32'h00000101);
        end
    endtask

    task automatic test_glitch_and_saturation();
        logic [31:0] q;
        apply_reset();
        button_in = 1'b1;
        repeat (10) tick();
        button_in = 1'b0;
        repeat (30) tick();
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h0) begin
            errors++; $display("FAIL glitch_rejected: got %h expected %h", q, 32'h0);
        end
        for (int p = 0; p < 300; p++) begin
            button_in = 1'b1;
            repeat (20) tick();
            button_in = 1'b0;
            repeat (20) tick();
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h0000FF02) begin
            errors++; $display("FAIL count_saturated: got %h expected %h", q, 32'h0000FF02);
        end
        do_store(32'd1000, 32'h80000000);
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h0) begin
            errors++; $display("FAIL count_cleared: got %h expected %h", q, 32'h0);
        end
    endtask

    task automatic test_timer_cmp();
        logic [31:0] q;
        apply_reset();
        do_store(32'd1002, 32'd100);
        do_store(32'd1001, 32'd90);
        repeat (10) tick();
        checks++;
        if (dut.timer_flag !== 1'b0) begin
            errors++; $display("FAIL flag_early: got %b expected %b", dut.timer_flag, 1'b0);
        end
        tick();
        checks++;
        if (dut.timer_flag !== 1'b1) begin
            errors++; $display("FAIL flag_set: got %b expected %b", dut.timer_flag, 1'b1);
        end
        // store+load together: the store wins and the flag is not cleared by the read
        address_dmem = 32'd1000;
        data = 32'h0;
        wren = 1'b1;
        rden = 1'b1;
        tick();
        wren = 1'b0;
        rden = 1'b0;
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h00000004) begin
            errors++; $display("FAIL flag_read: got %h expected %h", q, 32'h00000004);
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h0) begin
            errors++; $display("FAIL flag_clear_on_read: got %h expected %h", q, 32'h0);
        end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] q;
        apply_reset();
        do_store(32'd1001, 32'hFFFFFFFE);
        tick();
        tick();
        do_load(32'd1001, q);
        checks++;
        if (q !== 32'h0) begin
            errors++; $display("FAIL timer_wrap: got %h expected %h", q, 32'h0);
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h00000004) begin
            errors++; $display("FAIL wrap_hits_reset_cmp: got %h expected %h", q, 32'h00000004);
        end
    endtask

    task automatic test_read_collision();
        logic [31:0] q;
        apply_reset();
        button_in = 1'b1;
        repeat (17) tick();
        address_dmem = 32'd1000;
        rden = 1'b1;
        tick();
        rden = 1'b0;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++; $display("FAIL collision_read_value: got %h expected %h", q_dmem, 32'h0);
        end
        checks++;
        if (dut.press_pending !== 1'b1) begin
            errors++; $display("FAIL collision_pending_kept: got %b expected %b", dut.press_pending, 1'b1);
        end
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h00000103) begin
            errors++; $display("FAIL collision_followup: got %h expected %h", q, 32'h00000103);
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] q;
        apply_reset();
        button_in = 1'b1;
        repeat (10) tick();
        checks++;
        if (dut.db_cnt !== 4'd8) begin
            errors++; $display("FAIL mid_debounce_cnt: got %0d expected %0d", dut.db_cnt, 8);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dut.db_cnt !== 4'd0 || dut.btn_level !== 1'b0) begin
            errors++; $display("FAIL async_abort: cnt %0d level %b expected 0 0", dut.db_cnt, dut.btn_level);
        end
        button_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        address_dmem = 32'd1001;
        rden = 1'b1;
        tick();
        rden = 1'b0;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++; $display("FAIL cold_start_timer: got %h expected %h", q_dmem, 32'h0);
        end
        repeat (30) tick();
        do_load(32'd1000, q);
        checks++;
        if (q !== 32'h0) begin
            errors++; $display("FAIL no_press_after_abort: got %h expected %h", q, 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ram();
        test_button_press();
        test_glitch_and_saturation();
        test_timer_cmp();
        test_timer_wrap();
        test_read_collision();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
